// File: rtl/max_pool_stream.sv
// Streaming non-overlapping POOLxPOOL max-pool over IEEE-754 pixels in raster order.
// Define MAXPOOL_ARGMAX_EN to add Idx_Out, the in-window raster index of each maximum.
module max_pool_stream #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int POOL   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Data_In,
    input  logic              Valid_In,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Valid_Out,
    output logic              Frame_Done
`ifdef MAXPOOL_ARGMAX_EN
    ,
    output logic [$clog2(POOL*POOL)-1:0] Idx_Out
`endif
);

    localparam int SEGS  = IMG_W / POOL;
    localparam int WROWS = IMG_H / POOL;
    localparam int IW    = $clog2(POOL * POOL);
    localparam int PW    = $clog2(POOL);
    localparam int SW    = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam int RW    = (WROWS > 1) ? $clog2(WROWS) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] d;
`ifdef MAXPOOL_ARGMAX_EN
        logic [IW-1:0]     idx;
`endif
    } ent_t;

    // Sign-magnitude to unsigned ordering key: negatives inverted, positives above them.
    function automatic logic [DATA_W-1:0] okey(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? ~x : (x | {1'b1, {(DATA_W-1){1'b0}}});
    endfunction

    // a is the earlier pixel; it survives ties.
    function automatic ent_t pick(input ent_t a, input ent_t b);
        return (okey(b.d) > okey(a.d)) ? b : a;
    endfunction

    logic [PW-1:0] px;    // col % POOL
    logic [SW-1:0] seg;   // col / POOL
    logic [PW-1:0] pr;    // row % POOL
    logic [RW-1:0] wr;    // row / POOL

    ent_t h_max;
    ent_t lbuf [SEGS];
    ent_t cur, m, merged;

    logic last_px, last_seg, last_pr, last_wr;

    assign last_px  = (px  == PW'(POOL - 1));
    assign last_seg = (seg == SW'(SEGS - 1));
    assign last_pr  = (pr  == PW'(POOL - 1));
    assign last_wr  = (wr  == RW'(WROWS - 1));

    always_comb begin
        cur   = '0;
        cur.d = Data_In;
`ifdef MAXPOOL_ARGMAX_EN
        cur.idx = IW'(32'(pr) * POOL + 32'(px));
`endif
        m      = pick(h_max, cur);
        merged = pick(lbuf[seg], m);
    end

    // Top row of a window band overwrites, so stale contents after reset never leak.
    always_ff @(posedge clk) begin
        if (!rst && Valid_In && last_px && !last_pr)
            lbuf[seg] <= (pr == '0) ? m : merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px         <= '0;
            seg        <= '0;
            pr         <= '0;
            wr         <= '0;
            h_max      <= '0;
            Data_Out   <= '0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
            Idx_Out    <= '0;
`endif
        end else begin
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            if (Valid_In) begin
                h_max <= (px == '0) ? cur : m;
                if (last_px && last_pr) begin
                    Data_Out   <= merged.d;
                    Valid_Out  <= 1'b1;
                    Frame_Done <= last_seg && last_wr;
`ifdef MAXPOOL_ARGMAX_EN
                    Idx_Out    <= merged.idx;
`endif
                end
                if (last_px) begin
                    px <= '0;
                    if (last_seg) begin
                        seg <= '0;
                        if (last_pr) begin
                            pr <= '0;
                            wr <= last_wr ? '0 : wr + 1'b1;
                        end else begin
                            pr <= pr + 1'b1;
                        end
                    end else begin
                        seg <= seg + 1'b1;
                    end
                end else begin
                    px <= px + 1'b1;
                end
            end
        end
    end

endmodule
